systolic_mac_pe: RTL and testbench

- Parametrised output-stationary processing element for the systolic matrix-multiply array.
- Forwards A operands east and B operands south with registered valids.
- Accumulates A*B into a local accumulator with signed/unsigned and saturating/wrapping modes, plus tile clear.
- Unloads results through a per-row drain chain: each PE emits its own result, then passes its upstream neighbour's results through.

---
 rtl/systolic_mac_pe.sv | 139 +++++++++++++
 tb/tb_systolic_mac_pe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC processing element: forwards A east and B south,
// accumulates A*B locally, and unloads results through a per-row drain chain.
//
// state   | meaning
// S_IDLE  | accumulator holds 0, waiting for the first operand pair or drain
// S_ACC   | accumulating products of the current tile
// S_DRAIN | own result emitted, passing upstream results downstream
module systolic_mac_pe #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_a_in,
  input  logic              i_a_valid_in,
  input  logic [DATA_W-1:0] i_b_in,
  input  logic              i_b_valid_in,
  input  logic              i_clear,
  input  logic              i_drain,
  input  logic [ACC_W-1:0]  i_c_in,
  input  logic              i_c_valid_in,
  output logic [DATA_W-1:0] o_a_out,
  output logic              o_a_valid_out,
  output logic [DATA_W-1:0] o_b_out,
  output logic              o_b_valid_out,
  output logic [ACC_W-1:0]  o_c_out,
  output logic              o_c_valid_out,
  output logic              o_sat_flag,
  output logic              o_mac_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_t;

  localparam int   EXT_W     = ACC_W + 1;
  localparam int   PAD_W     = EXT_W - 2*DATA_W;
  localparam logic IS_SIGNED = (SIGNED != 0);
  localparam logic DO_SAT    = (SAT != 0);

  state_t              r_state;
  logic [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]   r_a_out, r_b_out;
  logic                r_a_valid, r_b_valid;
  logic [ACC_W-1:0]    r_c_out;
  logic                r_c_valid, r_sat, r_mac_err;

  logic [2*DATA_W-1:0] w_a_x, w_b_x, w_prod;
  logic [EXT_W-1:0]    w_prod_x, w_acc_x, w_sum;
  logic [ACC_W-1:0]    w_acc_next;
  logic                w_ovf, w_mac_fire;

  // Operands are pre-extended so one multiplier serves both signed and unsigned modes.
  assign w_a_x    = {{DATA_W{i_a_in[DATA_W-1] & IS_SIGNED}}, i_a_in};
  assign w_b_x    = {{DATA_W{i_b_in[DATA_W-1] & IS_SIGNED}}, i_b_in};
  assign w_prod   = w_a_x * w_b_x;
  assign w_prod_x = {{PAD_W{w_prod[2*DATA_W-1] & IS_SIGNED}}, w_prod};
  assign w_acc_x  = {r_acc[ACC_W-1] & IS_SIGNED, r_acc};
  assign w_sum    = w_acc_x + w_prod_x;

  assign w_mac_fire = i_a_valid_in & i_b_valid_in & (r_state != S_DRAIN);

  always_comb begin
    w_ovf      = IS_SIGNED ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    w_acc_next = w_sum[ACC_W-1:0];
    if (w_ovf && DO_SAT) begin
      if (!IS_SIGNED)
        w_acc_next = '1;
      else if (w_sum[ACC_W])
        w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      else
        w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_a_out   <= '0;
      r_a_valid <= 1'b0;
      r_b_out   <= '0;
      r_b_valid <= 1'b0;
      r_c_out   <= '0;
      r_c_valid <= 1'b0;
      r_sat     <= 1'b0;
      r_mac_err <= 1'b0;
    end else begin
      r_a_out   <= i_a_in;
      r_a_valid <= i_a_valid_in;
      r_b_out   <= i_b_in;
      r_b_valid <= i_b_valid_in;
      if (r_state == S_DRAIN) begin
        if (i_drain) begin
          r_c_out   <= i_c_in;
          r_c_valid <= i_c_valid_in;
        end else begin
          r_c_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
        if (i_a_valid_in && i_b_valid_in)
          r_mac_err <= 1'b1;
      end else if (i_drain) begin
        // Drain entry takes priority over clear and any operand pair.
        r_c_out   <= r_acc;
        r_c_valid <= 1'b1;
        r_acc     <= '0;
        r_sat     <= 1'b0;
        r_state   <= S_DRAIN;
      end else begin
        r_c_valid <= 1'b0;
        if (i_clear) begin
          r_sat <= 1'b0;
          if (w_mac_fire) begin
            r_acc   <= w_prod_x[ACC_W-1:0];
            r_state <= S_ACC;
          end else begin
            r_acc   <= '0;
            r_state <= S_IDLE;
          end
        end else if (w_mac_fire) begin
          r_acc   <= w_acc_next;
          r_sat   <= r_sat | w_ovf;
          r_state <= S_ACC;
        end
      end
    end
  end

  assign o_a_out       = r_a_out;
  assign o_a_valid_out = r_a_valid;
  assign o_b_out       = r_b_out;
  assign o_b_valid_out = r_b_valid;
  assign o_c_out       = r_c_out;
  assign o_c_valid_out = r_c_valid;
  assign o_sat_flag    = r_sat;
  assign o_mac_err     = r_mac_err;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Scoreboard bench for systolic_mac_pe: three 8x8->16 instances
// (0: signed/saturating, 1: signed/wrapping, 2: unsigned/saturating).
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_in [3];
  logic [7:0]  b_in [3];
  logic        av [3];
  logic        bv [3];
  logic        clr [3];
  logic        drn [3];
  logic [15:0] c_in [3];
  logic        cvi [3];
  logic [7:0]  a_out [3];
  logic [7:0]  b_out [3];
  logic        avo [3];
  logic        bvo [3];
  logic [15:0] c_out [3];
  logic        cvo [3];
  logic        sat [3];
  logic        merr [3];

  int checks = 0;
  int errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    systolic_mac_pe #(
      .DATA_W(8), .ACC_W(16), .SIGNED((g == 2) ? 0 : 1), .SAT((g == 1) ? 0 : 1)
    ) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_a_in(a_in[g]), .i_a_valid_in(av[g]),
      .i_b_in(b_in[g]), .i_b_valid_in(bv[g]),
      .i_clear(clr[g]), .i_drain(drn[g]),
      .i_c_in(c_in[g]), .i_c_valid_in(cvi[g]),
      .o_a_out(a_out[g]), .o_a_valid_out(avo[g]),
      .o_b_out(b_out[g]), .o_b_valid_out(bvo[g]),
      .o_c_out(c_out[g]), .o_c_valid_out(cvo[g]),
      .o_sat_flag(sat[g]), .o_mac_err(merr[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic [15:0] act);
    logic [15:0] e;
    int sz;
    case (d)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL c_out_unexpected dut%0d: got %0h expected no valid", d, act);
    end else begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("c_out dut%0d", d), {16'h0, act}, {16'h0, e});
    end
  endtask

  always @(negedge clk) begin
    if (cvo[0] === 1'b1) mon(0, c_out[0]);
    if (cvo[1] === 1'b1) mon(1, c_out[1]);
    if (cvo[2] === 1'b1) mon(2, c_out[2]);
  end

  task automatic push_exp(input int d, input logic [15:0] v);
    case (d)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      a_in[d] = '0; b_in[d] = '0; av[d] = 0; bv[d] = 0;
      clr[d] = 0; drn[d] = 0; c_in[d] = '0; cvi[d] = 0;
    end
  endtask

  task automatic rand_all();
    for (int d = 0; d < 3; d++) begin
      a_in[d] = 8'($urandom); b_in[d] = 8'($urandom);
      av[d] = 1'($urandom); bv[d] = 1'($urandom);
      clr[d] = 1'($urandom); drn[d] = 1'($urandom);
      c_in[d] = 16'($urandom); cvi[d] = 1'($urandom);
    end
  endtask

  task automatic mac(input int d, input logic [7:0] a, input logic [7:0] b);
    a_in[d] = a; b_in[d] = b; av[d] = 1; bv[d] = 1;
    step();
    check($sformatf("a_fwd dut%0d", d), {24'h0, a_out[d]}, {24'h0, a});
    check($sformatf("b_fwd dut%0d", d), {24'h0, b_out[d]}, {24'h0, b});
    av[d] = 0; bv[d] = 0;
  endtask

  task automatic drain_once(input int d, input logic [15:0] exp);
    drn[d] = 1;
    push_exp(d, exp);
    step();
    drn[d] = 0;
    step();
  endtask

  initial begin
    rst = 1;
    rand_all();
    step();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_fwd dut%0d", d),
            {14'h0, a_out[d], b_out[d], avo[d], bvo[d]}, 32'h0);
      check($sformatf("rst_c dut%0d", d), {13'h0, c_out[d], cvo[d], sat[d], merr[d]}, 32'h0);
    end
    rand_all();
    step();
    rst = 0;
    idle_all();
    step();

    // accumulate 3*4 + -2*5 + 7*7 = 51
    mac(0, 8'd3, 8'd4);
    mac(0, 8'hFE, 8'd5);
    mac(0, 8'd7, 8'd7);
    check("sat_clean", {31'h0, sat[0]}, 32'h0);
    drain_once(0, 16'd51);

    // signed saturation vs wrap: 3 * 16129
    for (int i = 0; i < 3; i++) begin
      mac(0, 8'd127, 8'd127);
      mac(1, 8'd127, 8'd127);
    end
    check("sat_flag_sat", {31'h0, sat[0]}, 32'h1);
    check("sat_flag_wrap", {31'h0, sat[1]}, 32'h1);
    drain_once(0, 16'h7FFF);
    drain_once(1, 16'hBD03);
    check("sat_cleared_drain", {31'h0, sat[0]}, 32'h0);
    check("wrap_cleared_drain", {31'h0, sat[1]}, 32'h0);

    // unsigned
    mac(2, 8'd255, 8'd255);
    check("usat_once", {31'h0, sat[2]}, 32'h0);
    drain_once(2, 16'd65025);
    mac(2, 8'd255, 8'd255);
    mac(2, 8'd255, 8'd255);
    check("usat_twice", {31'h0, sat[2]}, 32'h1);
    drain_once(2, 16'hFFFF);

    // clear with operand pair starts a new tile with the product
    mac(0, 8'd5, 8'd8);
    clr[0] = 1;
    mac(0, 8'd6, 8'd6);
    clr[0] = 0;
    drain_once(0, 16'd36);
    // clear alone
    mac(0, 8'd5, 8'd8);
    clr[0] = 1; step(); clr[0] = 0;
    mac(0, 8'd1, 8'd2);
    drain_once(0, 16'd2);
    // clear + drain together: drain wins
    mac(0, 8'd5, 8'd8);
    clr[0] = 1; drn[0] = 1;
    push_exp(0, 16'd40);
    step();
    clr[0] = 0; drn[0] = 0;
    step();
    drain_once(0, 16'd0);

    // drain chain with operand pair during DRAIN
    mac(0, 8'd2, 8'd3);
    drn[0] = 1;
    push_exp(0, 16'd6);
    step();
    c_in[0] = 16'h1111; cvi[0] = 1; a_in[0] = 8'd9; b_in[0] = 8'd9; av[0] = 1; bv[0] = 1;
    push_exp(0, 16'h1111);
    step();
    check("fwd_in_drain", {24'h0, a_out[0]}, 32'h9);
    c_in[0] = 16'h2222; av[0] = 0; bv[0] = 0;
    push_exp(0, 16'h2222);
    step();
    drn[0] = 0; cvi[0] = 0;
    step();
    check("mac_err_set", {31'h0, merr[0]}, 32'h1);
    drain_once(0, 16'd0);
    check("mac_err_sticky", {31'h0, merr[0]}, 32'h1);

    // one valid without the other: no MAC, no error
    a_in[1] = 8'd5; av[1] = 1; step(); av[1] = 0;
    b_in[1] = 8'd5; bv[1] = 1; step(); bv[1] = 0;
    mac(1, 8'd2, 8'd2);
    drain_once(1, 16'd4);
    check("no_err_single", {31'h0, merr[1]}, 32'h0);

    repeat (3) step();
    check("q0_empty", q0.size(), 32'h0);
    check("q1_empty", q1.size(), 32'h0);
    check("q2_empty", q2.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
